// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU and the control decoder that drives ALUOp.
package alu_pkg;

    localparam int unsigned ALU_W  = 32;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [OP_W-1:0] ALU_ADD  = 5'b00000;
    localparam logic [OP_W-1:0] ALU_SUB  = 5'b00001;
    localparam logic [OP_W-1:0] ALU_AND  = 5'b00010;
    localparam logic [OP_W-1:0] ALU_OR   = 5'b00011;
    localparam logic [OP_W-1:0] ALU_SLL  = 5'b00100;
    localparam logic [OP_W-1:0] ALU_SRL  = 5'b00101;
    localparam logic [OP_W-1:0] ALU_SRA  = 5'b00110;
    localparam logic [OP_W-1:0] ALU_XOR  = 5'b00111;
    localparam logic [OP_W-1:0] ALU_NOR  = 5'b01000;
    localparam logic [OP_W-1:0] ALU_SLT  = 5'b01001;
    localparam logic [OP_W-1:0] ALU_SLTU = 5'b01010;
    localparam logic [OP_W-1:0] ALU_LUI  = 5'b01011;

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter for SLL/SRL/SRA; all three results are produced in parallel.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [ALU_W-1:0]   value_in,
    output logic [ALU_W-1:0]   sll_out,
    output logic [ALU_W-1:0]   srl_out,
    output logic [ALU_W-1:0]   sra_out
);

    assign sll_out = value_in << shamt;
    assign srl_out = value_in >> shamt;
    assign sra_out = $unsigned($signed(value_in) >>> shamt);

endmodule

// File: rtl/alu.sv
// 32-bit EX-stage ALU: combinational op select followed by a single result register.
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ALU_W-1:0]  ALUIn1,
    input  logic [ALU_W-1:0]  ALUIn2,
    input  logic [OP_W-1:0]   ALUOp,
    output logic [ALU_W-1:0]  ALUOut
);

    logic [ALU_W-1:0] alu_out_d;
    logic [ALU_W-1:0] alu_out_q;
    logic [ALU_W-1:0] sll_res;
    logic [ALU_W-1:0] srl_res;
    logic [ALU_W-1:0] sra_res;
    logic             slt_res;
    logic             sltu_res;

    // Only the low five bits of operand A form the shift amount.
    alu_shifter u_shifter (
        .shamt    (ALUIn1[SHAMT_W-1:0]),
        .value_in (ALUIn2),
        .sll_out  (sll_res),
        .srl_out  (srl_res),
        .sra_out  (sra_res)
    );

    assign slt_res  = $signed(ALUIn1) < $signed(ALUIn2);
    assign sltu_res = ALUIn1 < ALUIn2;

    always_comb begin
        alu_out_d = '0;
        case (ALUOp)
            ALU_ADD:  alu_out_d = ALUIn1 + ALUIn2;
            ALU_SUB:  alu_out_d = ALUIn1 - ALUIn2;
            ALU_AND:  alu_out_d = ALUIn1 & ALUIn2;
            ALU_OR:   alu_out_d = ALUIn1 | ALUIn2;
            ALU_SLL:  alu_out_d = sll_res;
            ALU_SRL:  alu_out_d = srl_res;
            ALU_SRA:  alu_out_d = sra_res;
            ALU_XOR:  alu_out_d = ALUIn1 ^ ALUIn2;
            ALU_NOR:  alu_out_d = ~(ALUIn1 | ALUIn2);
            ALU_SLT:  alu_out_d = {{(ALU_W-1){1'b0}}, slt_res};
            ALU_SLTU: alu_out_d = {{(ALU_W-1){1'b0}}, sltu_res};
            ALU_LUI:  alu_out_d = {ALUIn2[15:0], 16'h0000};
            default:  alu_out_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_out_q <= '0;
        end else begin
            alu_out_q <= alu_out_d;
        end
    end

    assign ALUOut = alu_out_q;

endmodule

// File: tb/tb_alu.sv
// Directed plus randomized scoreboard bench for the alu; results are checked one cycle after drive.
module tb_alu;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] ALUIn1;
    logic [31:0] ALUIn2;
    logic [4:0]  ALUOp;
    logic [31:0] ALUOut;

    logic [31:0] expQ[$];
    int          compared   = 0;
    int          mismatched = 0;

    alu dut (
        .clk    (clk),
        .reset  (reset),
        .ALUIn1 (ALUIn1),
        .ALUIn2 (ALUIn2),
        .ALUOp  (ALUOp),
        .ALUOut (ALUOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    // Drives one operation and records what should appear on ALUOut after the next edge.
    task automatic applyStimulus(input logic rst, input logic [4:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp);
        reset  = rst;
        ALUOp  = op;
        ALUIn1 = a;
        ALUIn2 = b;
        expQ.push_back(exp);
    endtask

    task automatic checkOutput(input string tag);
        logic [31:0] exp;
        @(posedge clk);
        #1;
        compared++;
        if (expQ.size() == 0) begin
            mismatched++;
            $error("[TB] FAIL %s: observed empty scoreboard expected queued result", tag);
        end else begin
            exp = expQ.pop_front();
            assert (ALUOut === exp)
            else begin
                mismatched++;
                $error("[TB] FAIL %s: observed %h expected %h", tag, ALUOut, exp);
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [4:0]  op;

        reset  = 1'b1;
        ALUOp  = ALU_XOR;
        ALUIn1 = 32'hDEADBEEF;
        ALUIn2 = 32'h12345678;
        @(posedge clk);
        #1;

        applyStimulus(1'b1, ALU_OR, 32'hFFFF0000, 32'h0000FFFF, 32'h0);
        checkOutput("reset_any_inputs");
        applyStimulus(1'b1, ALU_ADD, 32'h1, 32'h2, 32'h0);
        checkOutput("reset_hold_add");

        applyStimulus(1'b0, ALU_SRL, 32'h5, 32'hF1234567, 32'h07891A2B);
        checkOutput("srl_5");
        applyStimulus(1'b0, ALU_SRA, 32'h5, 32'hF1234567, 32'hFF891A2B);
        checkOutput("sra_5");
        applyStimulus(1'b0, ALU_SLL, 32'h5, 32'hF1234567, 32'h2468ACE0);
        checkOutput("sll_5");
        applyStimulus(1'b0, ALU_SRL, 32'h25, 32'hF1234567, 32'h07891A2B);
        checkOutput("srl_upper_a_ignored");
        applyStimulus(1'b0, ALU_SRA, 32'hFFFFFFE0, 32'hF1234567, 32'hF1234567);
        checkOutput("sra_zero_shift");
        applyStimulus(1'b0, ALU_SLL, 32'h0, 32'h89ABCDEF, 32'h89ABCDEF);
        checkOutput("sll_zero_shift");
        applyStimulus(1'b0, ALU_SRA, 32'h1F, 32'h80000000, 32'hFFFFFFFF);
        checkOutput("sra_31");

        applyStimulus(1'b0, ALU_ADD, 32'hFFFFFFFF, 32'h1, 32'h0);
        checkOutput("add_wrap");
        applyStimulus(1'b0, ALU_SUB, 32'h0, 32'h1, 32'hFFFFFFFF);
        checkOutput("sub_wrap");
        applyStimulus(1'b0, ALU_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000);
        checkOutput("add_signed_ovf");

        applyStimulus(1'b0, ALU_SLT, 32'hFFFFFFFF, 32'h1, 32'h1);
        checkOutput("slt_neg");
        applyStimulus(1'b0, ALU_SLTU, 32'hFFFFFFFF, 32'h1, 32'h0);
        checkOutput("sltu_big");
        applyStimulus(1'b0, ALU_SLTU, 32'h1, 32'hFFFFFFFF, 32'h1);
        checkOutput("sltu_small");

        applyStimulus(1'b0, ALU_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0);
        checkOutput("and");
        applyStimulus(1'b0, ALU_OR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0);
        checkOutput("or");
        applyStimulus(1'b0, ALU_XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00);
        checkOutput("xor");
        applyStimulus(1'b0, ALU_NOR, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F);
        checkOutput("nor");
        applyStimulus(1'b0, ALU_LUI, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0FF00000);
        checkOutput("lui");

        applyStimulus(1'b0, 5'b11111, 32'h12345678, 32'h9ABCDEF0, 32'h0);
        checkOutput("illegal_1f");
        applyStimulus(1'b0, 5'b01100, 32'h12345678, 32'h9ABCDEF0, 32'h0);
        checkOutput("illegal_0c");

        applyStimulus(1'b0, ALU_ADD, 32'h10, 32'h20, 32'h30);
        checkOutput("pre_reset_add");
        applyStimulus(1'b1, ALU_SUB, 32'h50, 32'h8, 32'h0);
        checkOutput("midstream_reset");
        applyStimulus(1'b0, ALU_SUB, 32'h50, 32'h8, 32'h48);
        checkOutput("post_reset_sub");

        // Random back-to-back ops against an independent reference.
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            op = 5'($urandom_range(0, 11));
            case (op)
                ALU_ADD:  exp = a + b;
                ALU_SUB:  exp = a + (~b) + 32'd1;
                ALU_AND:  exp = a & b;
                ALU_OR:   exp = a | b;
                ALU_XOR:  exp = (a | b) & ~(a & b);
                ALU_NOR:  exp = ~a & ~b;
                ALU_SLL:  exp = b * (32'd1 << a[4:0]);
                ALU_SRL:  exp = b / (32'd1 << a[4:0]);
                ALU_SRA: begin
                    exp = b;
                    for (int k = 0; k < 32; k++) begin
                        if (k < int'(a[4:0])) exp = {b[31], exp[31:1]};
                    end
                end
                ALU_SLT: begin
                    if (a[31] != b[31]) exp = {31'b0, a[31]};
                    else exp = {31'b0, a < b};
                end
                ALU_SLTU: exp = (a < b) ? 32'd1 : 32'd0;
                default:  exp = {b[15:0], 16'h0};
            endcase
            applyStimulus(1'b0, op, a, b, exp);
            checkOutput($sformatf("rand_%0d_op%0d", i, op));
        end

        compared++;
        assert (expQ.size() == 0)
        else begin
            mismatched++;
            $error("[TB] FAIL scoreboard_drain: observed %0d expected 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
